// File: rtl/lcd_hd44780_ctrl.sv
// 4-bit HD44780 character-LCD controller: autonomous power-on init and display
// config, then a valid/ready host port for commands, data bytes and cursor moves.
module lcd_hd44780_ctrl #(
    parameter int unsigned T_POWERUP    = 750000,
    parameter int unsigned T_INIT1      = 205000,
    parameter int unsigned T_INIT2      = 5000,
    parameter int unsigned T_INIT3      = 2000,
    parameter int unsigned T_E_SETUP    = 2,
    parameter int unsigned T_E_HIGH     = 12,
    parameter int unsigned T_E_HOLD     = 2,
    parameter int unsigned T_NIBBLE_GAP = 50,
    parameter int unsigned T_CMD        = 2000,
    parameter int unsigned T_CLEAR      = 82000,
    parameter int unsigned NUM_ROWS     = 2,
    parameter int unsigned NUM_COLS     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_data,
    output logic       init_done,
    output logic       req_err,
    output logic [3:0] lcd_d,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw
);

    typedef enum logic [2:0] {
        S_PWRUP, S_SETUP, S_EHIGH, S_HOLD, S_GAP, S_WAIT, S_IDLE, S_ERR
    } state_t;

    localparam logic [7:0] FUNC_SET = (NUM_ROWS > 1) ? 8'h28 : 8'h20;

    state_t      state_q;
    logic [31:0] timer_q;
    logic [1:0]  init_cnt_q;
    logic [2:0]  cfg_idx_q;
    logic        is_byte_q;
    logic        hi_q;
    logic [7:0]  byte_q;
    logic        rs_q;
    logic        req_ready_q;
    logic        init_done_q;
    logic        req_err_q;
    logic [3:0]  lcd_d_q;
    logic        lcd_e_q;
    logic        lcd_rs_q;

    logic        timer_done;
    logic [31:0] post_wait_d;
    logic [31:0] init_wait_d;
    logic [1:0]  pos_row;
    logic [5:0]  pos_col;
    logic        pos_ok_d;
    logic [6:0]  row_base_d;
    logic [7:0]  pos_cmd_d;
    logic        launch_d;
    logic [7:0]  launch_byte_d;
    logic        launch_rs_d;

    function automatic logic [7:0] cfg_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    cfg_byte = FUNC_SET;
            3'd1:    cfg_byte = 8'h06;
            3'd2:    cfg_byte = 8'h0C;
            default: cfg_byte = 8'h01;
        endcase
    endfunction

    // Each phase is loaded with its length and ends on the cycle the timer reads 1.
    assign timer_done = (timer_q == 32'd1);

    // Clear and return-home need the long settle time; everything else is short.
    assign post_wait_d = (!rs_q && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03))
                         ? T_CLEAR : T_CMD;

    always_comb begin
        init_wait_d = T_INIT3;
        case (init_cnt_q)
            2'd0:    init_wait_d = T_INIT1;
            2'd1:    init_wait_d = T_INIT2;
            default: init_wait_d = T_INIT3;
        endcase
    end

    assign pos_row  = req_data[7:6];
    assign pos_col  = req_data[5:0];
    assign pos_ok_d = (32'(pos_row) < NUM_ROWS) && (32'(pos_col) < NUM_COLS);

    always_comb begin
        row_base_d = 7'h00;
        case (pos_row)
            2'd0: row_base_d = 7'h00;
            2'd1: row_base_d = 7'h40;
            2'd2: row_base_d = 7'h14;
            2'd3: row_base_d = 7'h54;
            default: row_base_d = 7'h00;
        endcase
    end

    assign pos_cmd_d = {1'b1, row_base_d + {1'b0, pos_col}};

    // Every path that begins a new byte transfer funnels through launch_d.
    always_comb begin
        launch_d      = 1'b0;
        launch_byte_d = 8'h00;
        launch_rs_d   = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (timer_done) begin
                    if (!is_byte_q && init_cnt_q == 2'd3) begin
                        launch_d      = 1'b1;
                        launch_byte_d = cfg_byte(3'd0);
                    end else if (is_byte_q && cfg_idx_q < 3'd3) begin
                        launch_d      = 1'b1;
                        launch_byte_d = cfg_byte(cfg_idx_q + 3'd1);
                    end
                end
            end
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    if (!req_op[1]) begin
                        launch_d      = 1'b1;
                        launch_byte_d = req_data;
                        launch_rs_d   = req_op[0];
                    end else if (req_op == 2'd2 && pos_ok_d) begin
                        launch_d      = 1'b1;
                        launch_byte_d = pos_cmd_d;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_PWRUP;
            timer_q     <= T_POWERUP;
            init_cnt_q  <= 2'd0;
            cfg_idx_q   <= 3'd0;
            is_byte_q   <= 1'b0;
            hi_q        <= 1'b0;
            byte_q      <= 8'h00;
            rs_q        <= 1'b0;
            req_ready_q <= 1'b0;
            init_done_q <= 1'b0;
            req_err_q   <= 1'b0;
            lcd_d_q     <= 4'h0;
            lcd_e_q     <= 1'b0;
            lcd_rs_q    <= 1'b0;
        end else begin
            req_err_q <= 1'b0;
            if (timer_q > 32'd1) timer_q <= timer_q - 32'd1;
            case (state_q)
                S_PWRUP: begin
                    if (timer_done) begin
                        state_q    <= S_SETUP;
                        timer_q    <= T_E_SETUP;
                        lcd_d_q    <= 4'h3;
                        lcd_rs_q   <= 1'b0;
                        is_byte_q  <= 1'b0;
                        init_cnt_q <= 2'd0;
                    end
                end
                S_SETUP: begin
                    if (timer_done) begin
                        state_q <= S_EHIGH;
                        timer_q <= T_E_HIGH;
                        lcd_e_q <= 1'b1;
                    end
                end
                S_EHIGH: begin
                    if (timer_done) begin
                        state_q <= S_HOLD;
                        timer_q <= T_E_HOLD;
                        lcd_e_q <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (timer_done) begin
                        if (is_byte_q && hi_q) begin
                            state_q <= S_GAP;
                            timer_q <= T_NIBBLE_GAP;
                        end else begin
                            state_q <= S_WAIT;
                            timer_q <= is_byte_q ? post_wait_d : init_wait_d;
                        end
                    end
                end
                S_GAP: begin
                    if (timer_done) begin
                        state_q <= S_SETUP;
                        timer_q <= T_E_SETUP;
                        lcd_d_q <= byte_q[3:0];
                        hi_q    <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (timer_done) begin
                        if (!is_byte_q) begin
                            if (init_cnt_q != 2'd3) begin
                                init_cnt_q <= init_cnt_q + 2'd1;
                                lcd_d_q    <= (init_cnt_q == 2'd2) ? 4'h2 : 4'h3;
                                state_q    <= S_SETUP;
                                timer_q    <= T_E_SETUP;
                            end
                        end else if (cfg_idx_q < 3'd3) begin
                            cfg_idx_q <= cfg_idx_q + 3'd1;
                        end else begin
                            cfg_idx_q   <= 3'd4;
                            init_done_q <= 1'b1;
                            req_ready_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end
                    end
                end
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        if (!launch_d) begin
                            req_err_q <= 1'b1;
                            state_q   <= S_ERR;
                        end
                    end
                end
                S_ERR: begin
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_PWRUP;
            endcase
            if (launch_d) begin
                byte_q    <= launch_byte_d;
                rs_q      <= launch_rs_d;
                lcd_rs_q  <= launch_rs_d;
                lcd_d_q   <= launch_byte_d[7:4];
                hi_q      <= 1'b1;
                is_byte_q <= 1'b1;
                state_q   <= S_SETUP;
                timer_q   <= T_E_SETUP;
            end
        end
    end

    assign req_ready = req_ready_q;
    assign init_done = init_done_q;
    assign req_err   = req_err_q;
    assign lcd_d     = lcd_d_q;
    assign lcd_e     = lcd_e_q;
    assign lcd_rs    = lcd_rs_q;
    assign lcd_rw    = 1'b0;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Bench for lcd_hd44780_ctrl: a 4-row/20-col instance checked against an expected
// strobe queue, plus a 1-row instance for single-line geometry.
`timescale 1ns/1ps
module tb_lcd_hd44780_ctrl;

    localparam int T_POWERUP    = 20;
    localparam int T_INIT1      = 10;
    localparam int T_INIT2      = 6;
    localparam int T_INIT3      = 4;
    localparam int T_E_SETUP    = 2;
    localparam int T_E_HIGH     = 3;
    localparam int T_E_HOLD     = 2;
    localparam int T_NIBBLE_GAP = 5;
    localparam int T_CMD        = 8;
    localparam int T_CLEAR      = 30;
    localparam int LO_GAP       = T_E_HOLD + T_NIBBLE_GAP + T_E_SETUP;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0, req_ready, init_done, req_err, lcd_e, lcd_rs, lcd_rw;
    logic [1:0] req_op = 2'd0;
    logic [7:0] req_data = 8'h00;
    logic [3:0] lcd_d;
    logic       req_valid_b = 1'b0, req_ready_b, init_done_b, req_err_b, lcd_e_b, lcd_rs_b, lcd_rw_b;
    logic [1:0] req_op_b = 2'd0;
    logic [7:0] req_data_b = 8'h00;
    logic [3:0] lcd_d_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc = 0;

    // {expected fall-to-rise gap (0 = unchecked), rs, nibble}
    logic [12:0] exp_q[$];
    logic [4:0]  obs_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    lcd_hd44780_ctrl #(
        .T_POWERUP(T_POWERUP), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_INIT3(T_INIT3),
        .T_E_SETUP(T_E_SETUP), .T_E_HIGH(T_E_HIGH), .T_E_HOLD(T_E_HOLD),
        .T_NIBBLE_GAP(T_NIBBLE_GAP), .T_CMD(T_CMD), .T_CLEAR(T_CLEAR),
        .NUM_ROWS(4), .NUM_COLS(20)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_data(req_data), .init_done(init_done), .req_err(req_err),
        .lcd_d(lcd_d), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw)
    );

    lcd_hd44780_ctrl #(
        .T_POWERUP(T_POWERUP), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_INIT3(T_INIT3),
        .T_E_SETUP(T_E_SETUP), .T_E_HIGH(T_E_HIGH), .T_E_HOLD(T_E_HOLD),
        .T_NIBBLE_GAP(T_NIBBLE_GAP), .T_CMD(T_CMD), .T_CLEAR(T_CLEAR),
        .NUM_ROWS(1), .NUM_COLS(16)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_op(req_op_b), .req_data(req_data_b), .init_done(init_done_b), .req_err(req_err_b),
        .lcd_d(lcd_d_b), .lcd_e(lcd_e_b), .lcd_rs(lcd_rs_b), .lcd_rw(lcd_rw_b)
    );

    // Strobe monitor for dut_a: pops the scoreboard on each lcd_e rise.
    logic        e_prev_a = 1'b0;
    int          rise_a = 0;
    int          fall_a = 0;
    logic [12:0] mon_exp;
    always @(negedge clk) begin
        if (!rst_n) begin
            e_prev_a = 1'b0;
        end else begin
            if (lcd_e && !e_prev_a) begin
                rise_a = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL strobe_unexpected got rs=%0b d=%h, none expected", lcd_rs, lcd_d);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if ({lcd_rs, lcd_d} !== mon_exp[4:0]) begin
                        failures++;
                        $display("FAIL strobe_nibble got rs=%0b d=%h exp rs=%0b d=%h",
                                 lcd_rs, lcd_d, mon_exp[4], mon_exp[3:0]);
                    end
                    if (mon_exp[12:5] != 8'd0) begin
                        checks++;
                        if (cyc - fall_a != int'(mon_exp[12:5])) begin
                            failures++;
                            $display("FAIL strobe_gap got %0d exp %0d", cyc - fall_a, mon_exp[12:5]);
                        end
                    end
                end
            end
            if (!lcd_e && e_prev_a) begin
                fall_a = cyc;
                checks++;
                if (cyc - rise_a != T_E_HIGH) begin
                    failures++;
                    $display("FAIL e_high_width got %0d exp %0d", cyc - rise_a, T_E_HIGH);
                end
            end
            e_prev_a = lcd_e;
        end
    end

    logic e_prev_b = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) e_prev_b = 1'b0;
        else begin
            if (lcd_e_b && !e_prev_b) obs_b.push_back({lcd_rs_b, lcd_d_b});
            e_prev_b = lcd_e_b;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_byte(input logic [7:0] b, input logic rs, input int gap_hi);
        exp_q.push_back({8'(gap_hi), rs, b[7:4]});
        exp_q.push_back({8'(LO_GAP), rs, b[3:0]});
    endtask

    task automatic push_init();
        exp_q.push_back({8'd0, 1'b0, 4'h3});
        exp_q.push_back({8'(T_E_HOLD + T_INIT1 + T_E_SETUP), 1'b0, 4'h3});
        exp_q.push_back({8'(T_E_HOLD + T_INIT2 + T_E_SETUP), 1'b0, 4'h3});
        exp_q.push_back({8'(T_E_HOLD + T_INIT3 + T_E_SETUP), 1'b0, 4'h2});
        push_byte(8'h28, 1'b0, T_E_HOLD + T_INIT3 + T_E_SETUP);
        push_byte(8'h06, 1'b0, T_E_HOLD + T_CMD + T_E_SETUP);
        push_byte(8'h0C, 1'b0, T_E_HOLD + T_CMD + T_E_SETUP);
        push_byte(8'h01, 1'b0, T_E_HOLD + T_CMD + T_E_SETUP);
    endtask

    task automatic send_req(input logic [1:0] op, input logic [7:0] data);
        for (int i = 0; i < 200 && !req_ready; i++) @(negedge clk);
        checks++;
        if (!req_ready) begin
            failures++;
            $display("FAIL req_ready_timeout got 0 exp 1");
        end
        req_valid = 1'b1;
        req_op    = op;
        req_data  = data;
        @(negedge clk);
        req_valid = 1'b0;
        acc_cyc   = cyc;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_drop got %0b exp 0", req_ready);
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 200 && !req_ready; i++) @(negedge clk);
    endtask

    task automatic run_init();
        int  rel;
        logic early_ready;
        early_ready = 1'b0;
        push_init();
        @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;
        for (int i = 0; i < 100 && !lcd_e; i++) @(negedge clk);
        checks++;
        if (!lcd_e || cyc - rel != 22) begin
            failures++;
            $display("FAIL first_strobe got cycle %0d e=%0b exp cycle 22", cyc - rel, lcd_e);
        end
        for (int i = 0; i < 2000 && !init_done; i++) begin
            if (req_ready) early_ready = 1'b1;
            @(negedge clk);
        end
        req_valid = 1'b0;
        checks++;
        if (early_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_before_init got 1 exp 0");
        end
        checks++;
        if (!init_done || cyc - fall_a != T_E_HOLD + T_CLEAR) begin
            failures++;
            $display("FAIL init_done_time got %0d done=%0b exp %0d", cyc - fall_a, init_done, T_E_HOLD + T_CLEAR);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_init got %0b exp 1", req_ready);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL init_leftover got %0d exp 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, init_done, req_err, lcd_d, lcd_e, lcd_rs, lcd_rw} !== 10'd0) begin
            failures++;
            $display("FAIL reset_a got %b exp 0", {req_ready, init_done, req_err, lcd_d, lcd_e, lcd_rs, lcd_rw});
        end
        checks++;
        if ({req_ready_b, init_done_b, req_err_b, lcd_d_b, lcd_e_b, lcd_rs_b, lcd_rw_b} !== 10'd0) begin
            failures++;
            $display("FAIL reset_b got %b exp 0", {req_ready_b, init_done_b, req_err_b, lcd_d_b, lcd_e_b, lcd_rs_b, lcd_rw_b});
        end
    endtask

    task automatic test_init();
        logic [4:0] exp_b[12];
        exp_b = '{5'h3, 5'h3, 5'h3, 5'h2, 5'h2, 5'h0, 5'h0, 5'h6, 5'h0, 5'hC, 5'h0, 5'h1};
        obs_b.delete();
        req_valid = 1'b1;
        req_op    = 2'd1;
        req_data  = 8'hAA;
        run_init();
        checks++;
        if (init_done_b !== 1'b1) begin
            failures++;
            $display("FAIL init_done_b got %0b exp 1", init_done_b);
        end
        checks++;
        if (obs_b.size() != 12) begin
            failures++;
            $display("FAIL one_row_count got %0d exp 12", obs_b.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                checks++;
                if (obs_b[i] !== exp_b[i]) begin
                    failures++;
                    $display("FAIL one_row_nibble[%0d] got %h exp %h", i, obs_b[i], exp_b[i]);
                end
            end
        end
    endtask

    task automatic test_data();
        push_byte(8'h41, 1'b1, 0);
        send_req(2'd1, 8'h41);
        wait_ready();
        checks++;
        if (!req_ready || cyc - fall_a != T_E_HOLD + T_CMD) begin
            failures++;
            $display("FAIL data_post_wait got %0d exp %0d", cyc - fall_a, T_E_HOLD + T_CMD);
        end
        checks++;
        if ({lcd_rs, lcd_d, lcd_rw} !== {1'b1, 4'h1, 1'b0}) begin
            failures++;
            $display("FAIL data_hold got rs=%0b d=%h rw=%0b exp rs=1 d=1 rw=0", lcd_rs, lcd_d, lcd_rw);
        end
    endtask

    task automatic test_commands();
        logic [7:0] cmds[6];
        int         waits[6];
        cmds  = '{8'h01, 8'h0C, 8'h02, 8'h03, 8'h04, 8'h80};
        waits = '{T_CLEAR, T_CMD, T_CLEAR, T_CLEAR, T_CMD, T_CMD};
        for (int i = 0; i < 6; i++) begin
            push_byte(cmds[i], 1'b0, 0);
            send_req(2'd0, cmds[i]);
            wait_ready();
            checks++;
            if (!req_ready || cyc - fall_a != T_E_HOLD + waits[i]) begin
                failures++;
                $display("FAIL cmd_post_wait[%h] got %0d exp %0d", cmds[i], cyc - fall_a, T_E_HOLD + waits[i]);
            end
        end
    endtask

    task automatic test_position();
        logic [1:0] ops[7];
        logic [7:0] datas[7];
        logic       errs[7];
        logic [7:0] cmds[7];
        ops   = '{2'd2, 2'd2, 2'd3, 2'd2, 2'd2, 2'd2, 2'd2};
        datas = '{8'h85, 8'h54, 8'h00, 8'hD3, 8'h00, 8'hD4, 8'h53};
        errs  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        cmds  = '{8'h99, 8'h00, 8'h00, 8'hE7, 8'h80, 8'h00, 8'hD3};
        for (int i = 0; i < 7; i++) begin
            if (!errs[i]) push_byte(cmds[i], 1'b0, 0);
            send_req(ops[i], datas[i]);
            checks++;
            if (req_err !== errs[i]) begin
                failures++;
                $display("FAIL pos_err[%0d] got %0b exp %0b", i, req_err, errs[i]);
            end
            if (errs[i]) begin
                @(negedge clk);
                checks++;
                if ({req_err, req_ready} !== 2'b01) begin
                    failures++;
                    $display("FAIL pos_err_pulse[%0d] got err=%0b ready=%0b exp err=0 ready=1", i, req_err, req_ready);
                end
            end else begin
                wait_ready();
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pos_leftover got %0d exp 0", exp_q.size());
        end
    endtask

    task automatic test_one_row();
        logic [7:0] datas[3];
        logic       errs[3];
        datas = '{8'h40, 8'h10, 8'h0F};
        errs  = '{1'b1, 1'b1, 1'b0};
        obs_b.delete();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 200 && !req_ready_b; j++) @(negedge clk);
            req_valid_b = 1'b1;
            req_op_b    = 2'd2;
            req_data_b  = datas[i];
            @(negedge clk);
            req_valid_b = 1'b0;
            checks++;
            if (req_err_b !== errs[i]) begin
                failures++;
                $display("FAIL one_row_err[%0d] got %0b exp %0b", i, req_err_b, errs[i]);
            end
        end
        for (int j = 0; j < 200 && !req_ready_b; j++) @(negedge clk);
        checks++;
        if (obs_b.size() != 2 || obs_b[0] !== 5'h08 || obs_b[1] !== 5'h0F) begin
            failures++;
            $display("FAIL one_row_pos got %0d strobes exp 2 (8,F)", obs_b.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] op;
        logic [7:0] data;
        for (int i = 0; i < 8; i++) begin
            op   = 2'($urandom_range(0, 1));
            data = 8'($urandom_range(0, 255));
            push_byte(data, op[0], 0);
            send_req(op, data);
        end
        wait_ready();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_leftover got %0d exp 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_strobe();
        push_byte(8'h55, 1'b1, 0);
        send_req(2'd1, 8'h55);
        for (int i = 0; i < 100 && !lcd_e; i++) @(negedge clk);
        for (int i = 0; i < 100 && lcd_e; i++) @(negedge clk);
        for (int i = 0; i < 100 && !lcd_e; i++) @(negedge clk);
        checks++;
        if (lcd_e !== 1'b1) begin
            failures++;
            $display("FAIL mid_strobe_reach got e=%0b exp 1", lcd_e);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({lcd_e, init_done, req_ready} !== 3'b000) begin
            failures++;
            $display("FAIL mid_reset_drop got e=%0b done=%0b ready=%0b exp 0", lcd_e, init_done, req_ready);
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
        run_init();
    endtask

    initial begin
        test_reset();
        test_init();
        test_data();
        test_commands();
        test_position();
        test_one_row();
        test_back_to_back();
        test_reset_mid_strobe();
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_hd44780_ctrl.md
Name: lcd_hd44780_ctrl

Overview:
Parametrised 4-bit HD44780 character-LCD controller. It performs power-on init and display config autonomously, then serves a host valid/ready request port carrying commands, data bytes and row/column cursor moves. It replaces the fixed-pattern LCD driver: timing, geometry and content now come from the host side of the display subsystem.

Parameters:
T_POWERUP, 750000, cycles of idle wait after reset before first init nibble
T_INIT1, 205000, wait after first 0x3 init nibble
T_INIT2, 5000, wait after second 0x3 init nibble
T_INIT3, 2000, wait after third 0x3 nibble and after the 0x2 nibble
T_E_SETUP, 2, lcd_d/lcd_rs stable before lcd_e rises
T_E_HIGH, 12, lcd_e high time per nibble
T_E_HOLD, 2, lcd_d held after lcd_e falls
T_NIBBLE_GAP, 50, gap between high-nibble hold end and low-nibble setup start
T_CMD, 2000, post-byte wait for ordinary commands/data
T_CLEAR, 82000, post-byte wait for clear/home commands
NUM_ROWS, 2, display rows, 1..4
NUM_COLS, 16, columns per row, 1..40

Ports:
clk  in  1  system clock
rst_n  in  1  async active-low reset
req_valid  in  1  host request valid
req_ready  out  1  controller can accept a request
req_op  in  2  0=command (RS=0), 1=data (RS=1), 2=set position, 3=reserved
req_data  in  8  byte; for op 2: [7:6]=row, [5:0]=col
init_done  out  1  init+config complete, sticky until reset
req_err  out  1  one-cycle pulse on rejected request
lcd_d  out  4  LCD data nibble
lcd_e  out  1  LCD enable strobe
lcd_rs  out  1  LCD register select
lcd_rw  out  1  LCD read/write, tied 0

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FSM to PWRUP, timer loaded with T_POWERUP; deassertion starts init. Reset mid-strobe drops lcd_e within the same cycle.
- Every timed phase lasts exactly its parameter in clk cycles (parameters >= 1).
- Init FSM: PWRUP -> N3a -> W1 -> N3b -> W2 -> N3c -> W3 -> N2 -> W3 -> CFG. Each Nx nibble: lcd_rs=0, lcd_d=value, T_E_SETUP, lcd_e=1 for T_E_HIGH, lcd_e=0 for T_E_HOLD, then the following wait.
- CFG sends bytes in order: function set (0x28 if NUM_ROWS>1 else 0x20), 0x06, 0x0C, 0x01. Then init_done=1, FSM to IDLE.
- Byte transfer (BYTE): high nibble, then T_NIBBLE_GAP, then low nibble (each as SETUP/E_HIGH/HOLD), then post wait. lcd_rs stays constant for the whole byte.
- Post wait is T_CLEAR when RS=0 and byte is 0x01, 0x02 or 0x03; otherwise T_CMD.
- req_ready=1 only in IDLE with init_done=1. Accept on req_valid&&req_ready; req_op/req_data are latched and req_ready drops the next cycle.
- Op 0/1: one BYTE with RS=op[0].
- Op 2: row<NUM_ROWS and col<NUM_COLS -> command 0x80|(base+col), with base = 0x00/0x40/0x14/0x54 for rows 0..3. Otherwise no LCD activity, req_err pulses the cycle after accept, return to IDLE.
- Op 3: rejected like an invalid position.
- lcd_d holds the last driven nibble between transfers. lcd_rw=0 always.
- req_valid while not ready is ignored (no queueing).

Test Plan:
- Small params (T_POWERUP=20, T_INIT1=10, T_INIT2=6, T_INIT3=4, T_E_SETUP=2, T_E_HIGH=3, T_E_HOLD=2, T_NIBBLE_GAP=5, T_CMD=8, T_CLEAR=30): release reset -> first lcd_e rise at cycle 22 with lcd_d=3. Nibble sequence 3,3,3,2 then 2,8,0,6,0,C,0,1. init_done rises after the 30-cycle clear wait.
- After init, op=1 data=0x41 -> lcd_rs=1, two lcd_e pulses of 3 cycles with lcd_d=4 then 1, 5-cycle gap between hold end and low-nibble setup, req_ready returns after 8-cycle post wait.
- op=0 data=0x01 -> 30-cycle post wait. op=0 data=0x0C -> 8-cycle post wait.
- NUM_ROWS=4, NUM_COLS=20: op=2 row=2 col=5 -> command 0x99 (nibbles 9,9). row=1 col=20 -> no lcd_e pulse, req_err one-cycle pulse. op=3 -> req_err.
- NUM_ROWS=1 -> function-set nibbles 2,0. op=2 row=1 col=0 -> req_err.
- Assert rst_n=0 while lcd_e=1 mid-data-byte -> lcd_e, init_done, req_ready drop immediately. On release, full init replays from PWRUP.
